// File: rtl/input_port_rx.sv
`default_nettype none
// ============================================================================
// Module   : input_port_rx
// Purpose  : Router input-port receiver. Buffers flits from one inter-router
//            link in a first-word-fall-through FIFO and presents the head flit
//            to the switch allocator together with its XY output direction.
//            The direction chosen by a head flit is held for the rest of the
//            wormhole packet.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            link_valid_in      - upstream flit write strobe
//            link_data_in       - upstream flit
//            link_full          - back-pressure, high when occupancy == DEPTH
//            sa_valid           - head flit is presentable to the allocator
//            sa_label           - output direction (0 L,1 N,2 E,3 S,4 W)
//            sa_data            - head flit (zero when the FIFO is empty)
//            sa_ready           - allocator accepted the presented flit
//            occupancy          - FIFO fill count
//            err_pulse          - one-cycle protocol / overflow error
// Options  : TIMESTAMP_AGE_EN   - when defined, each entry carries an 8-bit
//            residency counter and the presented timestamp field is the
//            stored timestamp plus age, saturating at 255.
// Params   : DEPTH must be a power of two, at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module input_port_rx #(
  parameter int DATASIZE = 40,
  parameter int DEPTH    = 4,
  parameter int MY_X     = 0,
  parameter int MY_Y     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      link_valid_in,
  input  logic [DATASIZE-1:0]       link_data_in,
  output logic                      link_full,
  output logic                      sa_valid,
  output logic [3:0]                sa_label,
  output logic [DATASIZE-1:0]       sa_data,
  input  logic                      sa_ready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      err_pulse
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(DEPTH);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [1:0] c_MY_X = 2'(MY_X);
  localparam logic [1:0] c_MY_Y = 2'(MY_Y);

  localparam logic [3:0] c_LBL_L = 4'd0;
  localparam logic [3:0] c_LBL_N = 4'd1;
  localparam logic [3:0] c_LBL_E = 4'd2;
  localparam logic [3:0] c_LBL_S = 4'd3;
  localparam logic [3:0] c_LBL_W = 4'd4;

  localparam logic [1:0] c_TYPE_SINGLE = 2'b00;
  localparam logic [1:0] c_TYPE_HEAD   = 2'b01;
  localparam logic [1:0] c_TYPE_BODY   = 2'b10;
  localparam logic [1:0] c_TYPE_TAIL   = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Dimension-ordered routing: resolve X first, then Y.
  function automatic logic [3:0] xy_route(input logic [3:0] dst);
    if (dst[1:0] > c_MY_X)      xy_route = c_LBL_E;
    else if (dst[1:0] < c_MY_X) xy_route = c_LBL_W;
    else if (dst[3:2] > c_MY_Y) xy_route = c_LBL_S;
    else if (dst[3:2] < c_MY_Y) xy_route = c_LBL_N;
    else                        xy_route = c_LBL_L;
  endfunction

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [DATASIZE-1:0] mem_d [DEPTH];
  logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_OCC_W-1:0]  occ_q, occ_d;
  state_t              state_q, state_d;
  logic [3:0]          route_q, route_d;
  logic                err_q, err_d;

  logic [DATASIZE-1:0] head_flit;
  logic [DATASIZE-1:0] head_out;
  logic [1:0]          head_type;
  logic [3:0]          head_route;
  logic                head_is_hdr;
  logic                not_empty;
  logic                push;
  logic                drop;
  logic                accept;
  logic                pop;

  assign not_empty   = (occ_q != '0);
  assign head_flit   = mem_q[rd_ptr_q];
  assign head_type   = head_flit[1:0];
  assign head_is_hdr = (head_type == c_TYPE_SINGLE) || (head_type == c_TYPE_HEAD);
  assign head_route  = xy_route(head_flit[35:32]);

  // Full is taken from the registered count, so a pop in the same cycle does
  // not open a slot for a simultaneous push.
  assign link_full = (occ_q == c_FULL);
  assign push      = link_valid_in && !link_full;

  // A body/tail reaching the head outside a packet has no route; it is
  // discarded without ever being presented.
  assign drop      = not_empty && (state_q == IDLE) && !head_is_hdr;

  assign sa_valid  = not_empty && (head_is_hdr || (state_q == PKT));
  assign sa_label  = ((state_q == PKT) && !head_is_hdr) ? route_q : head_route;
  assign accept    = sa_valid && sa_ready;
  assign pop       = accept || drop;

  assign sa_data   = not_empty ? head_out : '0;
  assign occupancy = occ_q;
  assign err_pulse = err_q;

  // A header arriving while a packet is open is an error, but it is still
  // accepted and starts a new packet.
  assign err_d = (link_valid_in && link_full) || drop ||
                 (accept && (state_q == PKT) && head_is_hdr);

`ifdef TIMESTAMP_AGE_EN
  logic [7:0] age_q [DEPTH];
  logic [7:0] age_d [DEPTH];
  logic [8:0] aged_sum;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = (age_q[i] == 8'hFF) ? age_q[i] : age_q[i] + 8'd1;
    end
    if (push) begin
      age_d[wr_ptr_q] = '0;
    end
  end

  assign aged_sum = {1'b0, head_flit[31:24]} + {1'b0, age_q[rd_ptr_q]};
  assign head_out = {head_flit[DATASIZE-1:32],
                     (aged_sum[8] ? 8'hFF : aged_sum[7:0]),
                     head_flit[23:0]};
`else
  assign head_out = head_flit;
`endif

  // FIFO next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = link_data_in;
      wr_ptr_d        = wr_ptr_q + c_PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + c_OCC_ONE;
      2'b01:   occ_d = occ_q - c_OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Packet tracking: only accepted flits move the state, drops never do.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      case (head_type)
        c_TYPE_HEAD: begin
          state_d = PKT;
          route_d = head_route;
        end
        c_TYPE_SINGLE: begin
          state_d = IDLE;
          route_d = head_route;
        end
        c_TYPE_BODY: state_d = PKT;
        c_TYPE_TAIL: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef TIMESTAMP_AGE_EN
        age_q[i] <= '0;
`endif
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= IDLE;
      route_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
`ifdef TIMESTAMP_AGE_EN
        age_q[i] <= age_d[i];
`endif
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      route_q  <= route_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_port_rx
// Purpose  : Self-checking bench for input_port_rx (router at X=1, Y=1).
//            Hand-derived vector table, a FIFO wrap sequence, a mid-packet
//            reset and random traffic against a queue-based packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_port_rx;

  localparam int DW    = 40;
  localparam int DEPTH = 4;
  localparam int MY_X  = 1;
  localparam int MY_Y  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          link_valid_in;
  logic [DW-1:0] link_data_in;
  logic          link_full;
  logic          sa_valid;
  logic [3:0]    sa_label;
  logic [DW-1:0] sa_data;
  logic          sa_ready;
  logic [2:0]    occupancy;
  logic          err_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  input_port_rx #(
    .DATASIZE(DW),
    .DEPTH   (DEPTH),
    .MY_X    (MY_X),
    .MY_Y    (MY_Y)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link_valid_in(link_valid_in),
    .link_data_in (link_data_in),
    .link_full    (link_full),
    .sa_valid     (sa_valid),
    .sa_label     (sa_label),
    .sa_data      (sa_data),
    .sa_ready     (sa_ready),
    .occupancy    (occupancy),
    .err_pulse    (err_pulse)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [39:0] flit;
    int          born;
  } ent_t;

  ent_t       q[$];
  bit         in_pkt;
  logic [3:0] route;
  bit         m_err;

  function automatic logic [3:0] xy(input logic [3:0] dst);
    int dx;
    int dy;
    dx = int'(dst[1:0]) - MY_X;
    dy = int'(dst[3:2]) - MY_Y;
    if (dx > 0) return 4'd2;
    if (dx < 0) return 4'd4;
    if (dy > 0) return 4'd3;
    if (dy < 0) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [39:0] m_data();
    logic [39:0] f;
`ifdef TIMESTAMP_AGE_EN
    int age;
    int ts;
`endif
    if (q.size() == 0) return 40'h0;
    f = q[0].flit;
`ifdef TIMESTAMP_AGE_EN
    age = cyc - q[0].born - 1;
    if (age > 255) age = 255;
    ts = int'(f[31:24]) + age;
    if (ts > 255) ts = 255;
    f[31:24] = ts[7:0];
`endif
    return f;
  endfunction

  function automatic logic [39:0] mk(input logic [3:0] dst, input logic [1:0] t,
                                     input logic [21:0] dat, input logic [7:0] ts);
    return {4'hA, dst, ts, dat, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [39:0] d;
    logic        r;
    logic        ev;
    logic [3:0]  el;
    logic [2:0]  eo;
    logic        ef;
    logic        ee;
  } vec_t;

  localparam int NTAB = 29;
  vec_t tab [NTAB];

  function automatic vec_t V(input bit v, input logic [39:0] d, input bit r,
                             input bit ev, input int el, input int eo,
                             input bit ef, input bit ee);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.ev = ev;
    x.el = 4'(el); x.eo = 3'(eo); x.ef = ef; x.ee = ee;
    return x;
  endfunction

  // One clock cycle: drive at negedge, compare just after, update model at posedge.
  task automatic step(input logic v, input logic [39:0] d, input logic r, input int ti);
    bit          hdr;
    bit          ev;
    bit          drop;
    bit          acc;
    bit          full_before;
    ent_t        e;
    @(negedge clk);
    link_valid_in = v;
    link_data_in  = d;
    sa_ready      = r;
    #1;
    hdr = (q.size() > 0) && (q[0].flit[1:0] < 2'd2);
    ev  = (q.size() > 0) && (hdr || in_pkt);
    chk("sa_valid", 64'(sa_valid), 64'(ev));
    if (ev) chk("sa_label", 64'(sa_label),
                64'((in_pkt && !hdr) ? route : xy(q[0].flit[35:32])));
    chk("sa_data", 64'(sa_data), 64'(m_data()));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("link_full", 64'(link_full), 64'(q.size() == DEPTH));
    chk("err_pulse", 64'(err_pulse), 64'(m_err));
    if (ti >= 0) begin
      chk("tab_valid", 64'(sa_valid), 64'(tab[ti].ev));
      if (tab[ti].ev) chk("tab_label", 64'(sa_label), 64'(tab[ti].el));
      chk("tab_occ", 64'(occupancy), 64'(tab[ti].eo));
      chk("tab_full", 64'(link_full), 64'(tab[ti].ef));
      chk("tab_err", 64'(err_pulse), 64'(tab[ti].ee));
    end
    @(posedge clk);
    full_before = (q.size() == DEPTH);
    drop  = (q.size() > 0) && !in_pkt && !hdr;
    acc   = ev && r;
    m_err = (v && full_before) || drop || (acc && in_pkt && hdr);
    if (drop || acc) begin
      e = q.pop_front();
      if (acc) begin
        case (e.flit[1:0])
          2'd0: in_pkt = 1'b0;
          2'd1: begin in_pkt = 1'b1; route = xy(e.flit[35:32]); end
          2'd3: in_pkt = 1'b0;
          default: ;
        endcase
      end
    end
    if (v && !full_before) begin
      e.flit = d;
      e.born = cyc;
      q.push_back(e);
    end
    cyc++;
  endtask

  // Asserted at a negedge and checked before any rising edge: proves the
  // clear does not wait for the clock.
  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    link_valid_in = 1'b0;
    link_data_in  = '0;
    sa_ready      = 1'b0;
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_full", 64'(link_full), 64'd0);
    chk("rst_valid", 64'(sa_valid), 64'd0);
    chk("rst_err", 64'(err_pulse), 64'd0);
    chk("rst_data", 64'(sa_data), 64'd0);
    q.delete();
    in_pkt = 1'b0;
    route  = '0;
    m_err  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [39:0] rd;
    rst           = 1'b1;
    link_valid_in = 1'b0;
    link_data_in  = '0;
    sa_ready      = 1'b0;

    // dst encodings at MY=(1,1): 5=L, 6=E, 1=N, 9=S, 4=W, 0=W
    tab[0]  = V(1, mk(4'h5, 2'd0, 22'd1, 8'h10), 0, 0, 0, 0, 0, 0);
    tab[1]  = V(0, 40'h0,                         1, 1, 0, 1, 0, 0);
    tab[2]  = V(0, 40'h0,                         0, 0, 0, 0, 0, 0);
    tab[3]  = V(1, mk(4'h6, 2'd1, 22'd2, 8'h10), 0, 0, 0, 0, 0, 0);
    tab[4]  = V(1, mk(4'h0, 2'd2, 22'd3, 8'h10), 1, 1, 2, 1, 0, 0);
    tab[5]  = V(1, mk(4'h0, 2'd3, 22'd4, 8'h10), 1, 1, 2, 1, 0, 0);
    tab[6]  = V(0, 40'h0,                         1, 1, 2, 1, 0, 0);
    tab[7]  = V(0, 40'h0,                         0, 0, 0, 0, 0, 0);
    tab[8]  = V(1, mk(4'h0, 2'd2, 22'd5, 8'h10), 0, 0, 0, 0, 0, 0);
    tab[9]  = V(0, 40'h0,                         1, 0, 0, 1, 0, 0);
    tab[10] = V(0, 40'h0,                         0, 0, 0, 0, 0, 1);
    tab[11] = V(0, 40'h0,                         0, 0, 0, 0, 0, 0);
    tab[12] = V(1, mk(4'h1, 2'd0, 22'd6, 8'h10), 0, 0, 0, 0, 0, 0);
    tab[13] = V(1, mk(4'h1, 2'd0, 22'd7, 8'h10), 0, 1, 1, 1, 0, 0);
    tab[14] = V(1, mk(4'h1, 2'd0, 22'd8, 8'h10), 0, 1, 1, 2, 0, 0);
    tab[15] = V(1, mk(4'h1, 2'd0, 22'd9, 8'h10), 0, 1, 1, 3, 0, 0);
    tab[16] = V(1, mk(4'h1, 2'd0, 22'd10, 8'h10), 0, 1, 1, 4, 1, 0);
    tab[17] = V(0, 40'h0,                         0, 1, 1, 4, 1, 1);
    tab[18] = V(1, mk(4'h1, 2'd0, 22'd11, 8'h10), 1, 1, 1, 4, 1, 0);
    tab[19] = V(0, 40'h0,                         1, 1, 1, 3, 0, 1);
    tab[20] = V(0, 40'h0,                         1, 1, 1, 2, 0, 0);
    tab[21] = V(0, 40'h0,                         1, 1, 1, 1, 0, 0);
    tab[22] = V(0, 40'h0,                         0, 0, 0, 0, 0, 0);
    tab[23] = V(1, mk(4'h9, 2'd1, 22'd12, 8'h10), 0, 0, 0, 0, 0, 0);
    tab[24] = V(1, mk(4'h4, 2'd1, 22'd13, 8'h10), 1, 1, 3, 1, 0, 0);
    tab[25] = V(1, mk(4'h0, 2'd2, 22'd14, 8'h10), 1, 1, 4, 1, 0, 0);
    tab[26] = V(1, mk(4'h5, 2'd3, 22'd15, 8'h10), 1, 1, 4, 1, 0, 1);
    tab[27] = V(0, 40'h0,                         1, 1, 4, 1, 0, 0);
    tab[28] = V(0, 40'h0,                         0, 0, 0, 0, 0, 0);

    do_reset();

    for (int i = 0; i < NTAB; i++) begin
      step(tab[i].v, tab[i].d, tab[i].r, i);
    end

    // Steady push+pop at occupancy 2 across several pointer wraps.
    for (int j = 0; j < 22; j++) begin
      if (j >= 2) begin
        #2;
        chk("wrap_occ", 64'(occupancy), 64'd2);
        chk("wrap_order", 64'(sa_data[23:2]), 64'(j - 2));
      end
      step(1'b1, mk(4'h5, 2'd0, 22'(j), 8'h10), (j >= 2), -1);
    end
    step(1'b0, 40'h0, 1'b1, -1);
    step(1'b0, 40'h0, 1'b1, -1);
    step(1'b0, 40'h0, 1'b0, -1);

    // Reset in the middle of a packet with flits buffered.
    step(1'b1, mk(4'h6, 2'd1, 22'd1, 8'h10), 1'b0, -1);
    step(1'b1, mk(4'h6, 2'd2, 22'd2, 8'h10), 1'b1, -1);
    step(1'b1, mk(4'h6, 2'd2, 22'd3, 8'h10), 1'b0, -1);
    do_reset();
    step(1'b1, mk(4'h0, 2'd2, 22'd4, 8'h10), 1'b0, -1);
    step(1'b0, 40'h0, 1'b1, -1);
    step(1'b0, 40'h0, 1'b0, -1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rd = mk(4'($urandom), 2'($urandom), 22'($urandom), 8'($urandom));
      step(($urandom_range(0, 99) < 55), rd, ($urandom_range(0, 99) < 50), -1);
    end
    for (int n = 0; n < 8; n++) step(1'b0, 40'h0, 1'b1, -1);

`ifdef TIMESTAMP_AGE_EN
    do_reset();
    step(1'b1, mk(4'h5, 2'd0, 22'd7, 8'd250), 1'b0, -1);
    for (int k = 0; k < 10; k++) step(1'b0, 40'h0, 1'b0, -1);
    #2;
    chk("age_sat", 64'(sa_data[31:24]), 64'd255);
    step(1'b0, 40'h0, 1'b1, -1);
    step(1'b0, 40'h0, 1'b0, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
